// File: rtl/dispense_controller.sv
// Fuel-pump transaction sequencer: latches a preset target, pulses the accumulator
// clear, runs the relay until the target is reached, with pause/abort and fault interlocks.
module dispense_controller #(
   parameter int unsigned TIMEOUT_CYC = 2000000,
   parameter int unsigned CLEAR_CYC   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_btn,
   input  logic        stop_btn,
   input  logic        fault_clr,
   input  logic        tank_low,
   input  logic [15:0] target_in,
   input  logic [15:0] vol_in,
   output logic        relay_on,
   output logic        clear_vol,
   output logic        done,
   output logic        aborted,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [2:0]  state_o
);

   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CLR_W = $clog2(CLEAR_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_PUMP  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t            state, next_state;
   logic              start_prev, stop_prev, clr_prev;
   logic              start_e, stop_e, clr_e, start_go;
   logic [15:0]       target_q;
   logic [15:0]       vol_prev;
   logic [WD_W-1:0]   wd;
   logic [CLR_W-1:0]  clr_cnt;
   logic [1:0]        next_code;
   logic              latch_target;
   logic              abort_set;

   assign start_e  = start_btn & ~start_prev;
   assign stop_e   = stop_btn & ~stop_prev;
   assign clr_e    = fault_clr & ~clr_prev;
   // A simultaneous stop edge always takes precedence over start.
   assign start_go = start_e & ~stop_e;
   assign state_o  = state;

   always_comb begin
      next_state   = state;
      next_code    = fault_code;
      latch_target = 1'b0;
      abort_set    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start_go && target_in != 16'd0) begin
               if (tank_low) begin
                  next_state = S_FAULT;
                  next_code  = 2'd1;
               end else begin
                  next_state   = S_CLEAR;
                  latch_target = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            if (tank_low) begin
               next_state = S_FAULT;
               next_code  = 2'd1;
            end else if (clr_cnt == CLR_W'(CLEAR_CYC - 1)) begin
               next_state = S_PUMP;
            end
         end
         S_PUMP: begin
            if (tank_low) begin
               next_state = S_FAULT;
               next_code  = 2'd1;
            end else if (vol_in >= target_q) begin
               next_state = S_DONE;
            end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
               next_state = S_FAULT;
               next_code  = 2'd2;
            end else if (stop_e) begin
               next_state = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (stop_e) begin
               next_state = S_DONE;
               abort_set  = 1'b1;
            end else if (start_go) begin
               if (tank_low) begin
                  next_state = S_FAULT;
                  next_code  = 2'd1;
               end else begin
                  next_state = S_PUMP;
               end
            end
         end
         S_FAULT: begin
            if (clr_e && !tank_low) begin
               next_state = S_IDLE;
               next_code  = 2'd0;
            end
         end
         default: begin
            next_state = S_IDLE;
            next_code  = 2'd0;
         end
      endcase
   end

   // Outputs are registered from next_state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         start_prev <= 1'b1;
         stop_prev  <= 1'b1;
         clr_prev   <= 1'b1;
         target_q   <= '0;
         vol_prev   <= '0;
         wd         <= '0;
         clr_cnt    <= '0;
         relay_on   <= 1'b0;
         clear_vol  <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 2'd0;
      end else begin
         state      <= next_state;
         start_prev <= start_btn;
         stop_prev  <= stop_btn;
         clr_prev   <= fault_clr;
         vol_prev   <= vol_in;
         if (latch_target)
            target_q <= target_in;
         // Watchdog restarts on PUMP entry and on any movement of the volume feed.
         if (state == S_PUMP && next_state == S_PUMP && vol_in == vol_prev)
            wd <= wd + 1'b1;
         else
            wd <= '0;
         if (state == S_CLEAR && next_state == S_CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
         else
            clr_cnt <= '0;
         relay_on   <= (next_state == S_PUMP);
         clear_vol  <= (next_state == S_CLEAR);
         done       <= (next_state == S_DONE);
         fault      <= (next_state == S_FAULT);
         fault_code <= next_code;
         if (latch_target)
            aborted <= 1'b0;
         else if (abort_set)
            aborted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: timestamped output-change scoreboard fed by a
// cycle-stamped behavioural model, directed scenarios followed by random operation.
module tb_dispense_controller;

   localparam int TIMEOUT = 100;
   localparam int CLRC    = 4;
   localparam int M_IDLE = 0, M_CLEAR = 1, M_PUMP = 2, M_PAUSE = 3, M_DONE = 4, M_FAULT = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_btn, stop_btn, fault_clr, tank_low;
   logic [15:0] target_in, vol_in;
   logic        relay_on, clear_vol, done, aborted, fault;
   logic [1:0]  fault_code;
   logic [2:0]  state_o;

   dispense_controller #(.TIMEOUT_CYC(TIMEOUT), .CLEAR_CYC(CLRC)) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .stop_btn(stop_btn),
      .fault_clr(fault_clr), .tank_low(tank_low), .target_in(target_in), .vol_in(vol_in),
      .relay_on(relay_on), .clear_vol(clear_vol), .done(done), .aborted(aborted),
      .fault(fault), .fault_code(fault_code), .state_o(state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic        sb_en = 1'b0;
   logic [19:0] cyc = '0;
   logic [29:0] exp_q[$];

   // ---------------- reference model ----------------
   int          m_state;
   logic [1:0]  m_code;
   logic        m_aborted;
   logic [15:0] m_target, m_last_vol;
   int          m_clear_at, m_ref;
   logic        m_ps, m_pt, m_pf;
   logic [9:0]  m_prev_outs;

   function automatic logic [9:0] model_outs();
      logic [2:0] s;
      s = m_state[2:0];
      return {m_state == M_PUMP, m_state == M_CLEAR, m_state == M_DONE, m_aborted,
              m_state == M_FAULT, m_code, s};
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_code = 2'd0; m_aborted = 1'b0; m_target = '0; m_last_vol = '0;
      m_clear_at = 0; m_ref = 0; m_ps = 1'b1; m_pt = 1'b1; m_pf = 1'b1;
      m_prev_outs = '0;
      exp_q.delete();
   endtask

   task automatic go_fault(input logic [1:0] code);
      m_state = M_FAULT; m_code = code;
   endtask

   task automatic model_step();
      logic se, te, fe, changed;
      int c;
      logic [9:0] o;
      c  = int'(cyc);
      se = start_btn & ~m_ps;
      te = stop_btn & ~m_pt;
      fe = fault_clr & ~m_pf;
      if (te) se = 1'b0;
      changed = (vol_in != m_last_vol);
      case (m_state)
         M_IDLE, M_DONE:
            if (se && target_in != 0) begin
               if (tank_low) go_fault(2'd1);
               else begin
                  m_state = M_CLEAR; m_target = target_in; m_aborted = 1'b0; m_clear_at = c;
               end
            end
         M_CLEAR:
            if (tank_low) go_fault(2'd1);
            else if (c - m_clear_at == CLRC) begin m_state = M_PUMP; m_ref = c; end
         M_PUMP: begin
            if (tank_low) go_fault(2'd1);
            else if (vol_in >= m_target) m_state = M_DONE;
            else if (c - m_ref == TIMEOUT) go_fault(2'd2);
            else if (te) m_state = M_PAUSE;
            if (changed) m_ref = c;
         end
         M_PAUSE:
            if (te) begin m_state = M_DONE; m_aborted = 1'b1; end
            else if (se) begin
               if (tank_low) go_fault(2'd1);
               else begin m_state = M_PUMP; m_ref = c; end
            end
         M_FAULT:
            if (fe && !tank_low) begin m_state = M_IDLE; m_code = 2'd0; end
         default: m_state = M_IDLE;
      endcase
      m_last_vol = vol_in;
      m_ps = start_btn; m_pt = stop_btn; m_pf = fault_clr;
      o = model_outs();
      if (o != m_prev_outs) exp_q.push_back({cyc, o});
      m_prev_outs = o;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         cyc = cyc + 1'b1;
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [9:0]  cur, prev_outs;
      logic [29:0] e;
      prev_outs = '0;
      forever begin
         @(negedge clk);
         cur = {relay_on, clear_vol, done, aborted, fault, fault_code, state_o};
         if (!sb_en) prev_outs = '0;
         else if (cur != prev_outs) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL out_change cyc=%0d got outs=%b, expected no change", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e != {cyc, cur}) begin
                  failures++;
                  $display("FAIL out_change got cyc=%0d outs=%b, expected cyc=%0d outs=%b",
                           cyc, cur, e[29:10], e[9:0]);
               end
            end
            prev_outs = cur;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   task automatic press_start();
      start_btn = 1'b1; tick(1); start_btn = 1'b0;
   endtask

   task automatic press_stop();
      stop_btn = 1'b1; tick(1); stop_btn = 1'b0;
   endtask

   task automatic press_clr();
      fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
   endtask

   // Begin a transaction; the accumulator is zeroed while the clear pulse is high.
   task automatic begin_txn(input logic [15:0] tgt);
      target_in = tgt;
      press_start();
      tick(1);
      vol_in = '0;
      tick(CLRC + 1);
   endtask

   task automatic do_reset();
      sb_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_reset_relay", {15'd0, relay_on}, 16'd0);
      check("async_reset_state", {13'd0, state_o}, 16'd0);
      tick(3);
      rst_n = 1'b1;
      tick(1);
      sb_en = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; start_btn = 1'b0; stop_btn = 1'b0; fault_clr = 1'b0; tank_low = 1'b0;
      target_in = '0; vol_in = '0;
      tick(3);
      check("reset_outputs", {6'd0, relay_on, clear_vol, done, aborted, fault, fault_code, state_o},
            16'd0);
      rst_n = 1'b1;
      tick(1);
      sb_en = 1'b1;

      // zero target is ignored
      target_in = 16'd0; press_start(); tick(5);
      check("zero_target_state", {13'd0, state_o}, 16'd0);

      // normal fill
      target_in = 16'd150; press_start();
      check("t1_clear_vol", {15'd0, clear_vol}, 16'd1);
      tick(4);
      check("t1_relay", {15'd0, relay_on}, 16'd1);
      tick(15); vol_in = 16'd50; tick(20); vol_in = 16'd100; tick(20); vol_in = 16'd150; tick(1);
      check("t1_done", {15'd0, done}, 16'd1);
      check("t1_state", {13'd0, state_o}, 16'd4);
      check("t1_relay_off", {15'd0, relay_on}, 16'd0);

      // overshoot
      begin_txn(16'd120);
      for (int i = 1; i <= 3; i++) begin vol_in = 16'(50 * i); tick(10); end

      // pause / resume / abort
      begin_txn(16'd200);
      vol_in = 16'd50; tick(10); vol_in = 16'd100; tick(10);
      press_stop(); tick(30);
      press_start(); tick(10);
      press_stop(); tick(5); press_stop(); tick(3);
      check("t3_aborted", {15'd0, aborted}, 16'd1);

      // stall
      begin_txn(16'd300);
      vol_in = 16'd50; tick(120);
      check("t4_fault_code", {14'd0, fault_code}, 16'd2);
      press_clr(); tick(3);

      // tank interlocks
      begin_txn(16'd200);
      vol_in = 16'd50; tick(5); tank_low = 1'b1; tick(3);
      press_clr(); tick(3);
      check("t5_fault_held", {15'd0, fault}, 16'd1);
      tank_low = 1'b0; tick(2); press_clr(); tick(3);
      tank_low = 1'b1; target_in = 16'd80; press_start(); tick(3);
      tank_low = 1'b0; tick(1); press_clr(); tick(3);

      // simultaneous start/stop in PAUSE
      begin_txn(16'd200);
      vol_in = 16'd60; tick(5); press_stop(); tick(5);
      start_btn = 1'b1; stop_btn = 1'b1; tick(1); start_btn = 1'b0; stop_btn = 1'b0; tick(3);

      // button held through reset release
      start_btn = 1'b1; target_in = 16'd90;
      do_reset(); tick(10); start_btn = 1'b0; tick(5);
      check("held_btn_idle", {13'd0, state_o}, 16'd0);

      // reset mid-PUMP
      begin_txn(16'd200);
      vol_in = 16'd20; tick(5);
      do_reset(); tick(3);

      // random operation
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 4) start_btn = ~start_btn;
         if ($urandom_range(0, 99) < 2) stop_btn = ~stop_btn;
         if ($urandom_range(0, 99) < 4) fault_clr = ~fault_clr;
         if ($urandom_range(0, 999) < 8) tank_low = ~tank_low;
         if ($urandom_range(0, 49) == 0) target_in = 16'($urandom_range(0, 300));
         if (m_state == M_CLEAR) vol_in = '0;
         else if (m_state == M_PUMP && $urandom_range(0, 3) == 0)
            vol_in = vol_in + 16'($urandom_range(0, 15));
         tick(1);
      end

      start_btn = 1'b0; stop_btn = 1'b0; fault_clr = 1'b0;
      tick(5);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
